// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed common-anode 7-segment scanner with load-strobed shadow registers.
// Ports: clock, rst_n (async active-low), load (captures value/dp/blink), value (hex nibbles),
// dp (per-digit decimal point), blink (per-digit blink), enable (0 blanks at next tick),
// seg (active-low, seg[7]=dp), an (active-low anodes).
// Optional macro SEG_LZ_BLANK_EN blanks leading-zero digits (digit 0 is never blanked).
module seg_scan_display #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 125000,
    parameter int BLINK_DIV = 21
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  enable,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       bcnt;
    logic                phase_off;
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blink;
    logic                tick;
    logic [3:0]          nib;
    logic [6:0]          glyph;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign tick = pre == PW'(SCAN_DIV - 1);
    assign nib  = sh_val[{idx, 2'b00} +: 4];

`ifdef SEG_LZ_BLANK_EN
    // lz[i] is set when every nibble from i up to the top digit is zero
    logic [DIGITS-1:0] lz;
    always_comb begin
        logic z;
        lz = '0;
        z  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z     = z && (sh_val[4*i +: 4] == 4'd0);
            lz[i] = z;
        end
    end
    assign glyph = (idx != '0 && lz[idx]) ? 7'h7F : dec(nib);
`else
    assign glyph = dec(nib);
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pre       <= '0;
            idx       <= '0;
            bcnt      <= '0;
            phase_off <= 1'b0;
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_blink  <= '0;
            seg       <= 8'hFF;
            an        <= '1;
        end else begin
            // shadows update after this edge, so a coincident tick still shows the old frame
            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp;
                sh_blink <= blink;
            end
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                an        <= enable ? ~(DIGITS'(1) << idx) : '1;
                seg       <= (!enable || (sh_blink[idx] && phase_off)) ? 8'hFF : {~sh_dp[idx], glyph};
                idx       <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
                bcnt      <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
                phase_off <= bcnt == BW'(BLINK_DIV - 1) ? ~phase_off : phase_off;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: self-checking bench for seg_scan_display against a tick-count based model.
module tb_seg_scan_display;
    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BD = 3;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink = '0;
    logic [7:0]  seg;
    logic [3:0]  an;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clock = ~clock;

    seg_scan_display #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clock(clock), .rst_n(rst_n), .load(load), .value(value), .dp(dp),
        .blink(blink), .enable(enable), .seg(seg), .an(an)
    );

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: edges since reset release decide tick number, digit and blink phase directly.
    int          ecnt = 0;
    int          t, d;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_bl = '0;
    logic [3:0]  nib;
    logic [7:0]  e_seg = 8'hFF;
    logic [3:0]  e_an = 4'hF;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ecnt  = 0;
            m_val = '0;
            m_dp  = '0;
            m_bl  = '0;
            e_seg = 8'hFF;
            e_an  = 4'hF;
        end else begin
            if (ecnt % SD == SD - 1) begin
                t = ecnt / SD;
                d = t % D;
                nib = m_val[4*d +: 4];
                if (!enable) begin
                    e_seg = 8'hFF;
                    e_an  = 4'hF;
                end else begin
                    e_an = ~(4'b0001 << d);
                    if (m_bl[d] && (t / BD) % 2 == 1) e_seg = 8'hFF;
                    else begin
                        e_seg = {~m_dp[d], glyph_tab[nib][6:0]};
`ifdef SEG_LZ_BLANK_EN
                        if (d > 0 && (m_val >> (4 * d)) == 16'd0) e_seg[6:0] = 7'h7F;
`endif
                    end
                end
            end
            if (load) begin
                m_val = value;
                m_dp  = dp;
                m_bl  = blink;
            end
            ecnt++;
        end
    end

    always @(negedge clock) begin
        chk("seg_model", seg, e_seg);
        chk("an_model", {4'b0, an}, {4'b0, e_an});
    end

    task automatic do_reset();
        @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_seg_async", seg, 8'hFF);
        chk("reset_an_async", {4'b0, an}, 8'h0F);
        @(negedge clock);
        #2 rst_n = 1'b1;
    endtask

    task automatic expect_digit(input int dg, input logic [7:0] s);
        logic [3:0] want;
        int k;
        want = ~(4'b0001 << dg);
        for (k = 0; k < 40 && an !== want; k++) @(negedge clock);
        chk("digit_an", {4'b0, an}, {4'b0, want});
        chk($sformatf("digit%0d_seg", dg), seg, s);
    endtask

    logic [7:0] first_seg [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_seg", seg, 8'hFF);
        chk("reset_an", {4'b0, an}, 8'h0F);
        #2 rst_n = 1'b1;
        load = 1'b1;
        value = 16'h1234;
        @(negedge clock);
        load = 1'b0;
        chk("pre_tick_seg", seg, 8'hFF);
        repeat (2) begin
            @(negedge clock);
            chk("pre_tick_seg", seg, 8'hFF);
            chk("pre_tick_an", {4'b0, an}, 8'h0F);
        end
        @(negedge clock);
        chk("first_tick_seg", seg, first_seg[0]);
        chk("first_tick_an", {4'b0, an}, 8'h0E);
        for (int i = 1; i < 4; i++) begin
            repeat (4) @(negedge clock);
            chk("scan_seg", seg, first_seg[i]);
            chk("scan_an", {4'b0, an}, {4'b0, ~(4'b0001 << i)});
        end

        value = 16'hABCF;
        dp = 4'b1000;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (16) @(negedge clock);
        expect_digit(0, 8'h8E);
        expect_digit(1, 8'hC6);
        expect_digit(2, 8'h83);
        expect_digit(3, 8'h08);

        do_reset();
        value = 16'h0000;
        dp = 4'b0000;
        blink = 4'b0001;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (3) @(negedge clock);
        chk("blink_on_seg", seg, 8'hC0);
        chk("blink_on_an", {4'b0, an}, 8'h0E);
        repeat (16) @(negedge clock);
        chk("blink_off_seg", seg, 8'hFF);
        chk("blink_off_an", {4'b0, an}, 8'h0E);
        repeat (16) @(negedge clock);
        chk("blink_back_seg", seg, 8'hC0);

        blink = 4'b0000;
        repeat (15) @(negedge clock);
        value = 16'h0005;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        chk("collide_old_seg", seg, 8'hC0);
        chk("collide_old_an", {4'b0, an}, 8'h0E);
        repeat (16) @(negedge clock);
        chk("collide_new_seg", seg, 8'h92);
        chk("collide_new_an", {4'b0, an}, 8'h0E);

        enable = 1'b0;
        repeat (4) @(negedge clock);
        chk("disable_seg", seg, 8'hFF);
        chk("disable_an", {4'b0, an}, 8'h0F);
        enable = 1'b1;

        do_reset();
        repeat (4) @(negedge clock);
        chk("restart_seg", seg, 8'hC0);
        chk("restart_an", {4'b0, an}, 8'h0E);

        value = 16'h0070;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (16) @(negedge clock);
`ifdef SEG_LZ_BLANK_EN
        expect_digit(3, 8'hFF);
        expect_digit(2, 8'hFF);
`else
        expect_digit(3, 8'hC0);
        expect_digit(2, 8'hC0);
`endif
        expect_digit(1, 8'hF8);
        expect_digit(0, 8'hC0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) do_reset();
            else @(negedge clock);
            load   = $urandom_range(5) == 0;
            value  = 16'($urandom);
            dp     = 4'($urandom);
            blink  = 4'($urandom);
            enable = $urandom_range(9) != 0;
        end
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
